// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcode and phase encodings
// and the ALU-operation decode used by the sequencer and the ALU.
package cpu_pkg;

    localparam int unsigned NPHASE = 8;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        PH_0 = 3'd0,
        PH_1 = 3'd1,
        PH_2 = 3'd2,
        PH_3 = 3'd3,
        PH_4 = 3'd4,
        PH_5 = 3'd5,
        PH_6 = 3'd6,
        PH_7 = 3'd7
    } phase_e;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: 8-phase fetch/execute counter with halt
// latch, decoding phase/opcode/zero into datapath and memory strobes.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt
);

    phase_e  phase_q, phase_d;
    logic    halted_q, halted_d;
    opcode_e op;
    logic    alu;

    assign op  = opcode_e'(opcode);
    assign alu = is_aluop(op);

    // Next phase and halt latch: advance on run, freeze once halted.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q && run) begin
            if (phase_q == PH_4 && op == OP_HLT) begin
                halted_d = 1'b1;
            end
            if (32'(phase_q) == NPHASE - 1) begin
                phase_d = PH_0;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    // State registers with synchronous reset taking priority over run.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Strobe decode from phase/opcode/zero, with stall gating and halt override.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (phase_q)
            PH_0: sel = 1'b1;
            PH_1: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_2, PH_3: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_4: begin
                inc_pc = 1'b1;
                halt   = (op == OP_HLT);
            end
            PH_5: rd = alu;
            PH_6: begin
                rd     = alu;
                inc_pc = (op == OP_SKZ) && zero;
                ld_pc  = (op == OP_JMP);
                data_e = (op == OP_STO);
            end
            PH_7: begin
                rd     = alu;
                ld_ac  = alu;
                inc_pc = (op == OP_JMP);
                ld_pc  = (op == OP_JMP);
                wr     = (op == OP_STO);
                data_e = (op == OP_STO);
            end
            default: ;
        endcase
        if (!run) begin
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
        end
        if (halted_q) begin
            sel    = 1'b0;
            rd     = 1'b0;
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
            data_e = 1'b0;
            halt   = 1'b1;
        end
    end

    assign phase = phase_q;

endmodule
